// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types, port count and lane helpers for the data-memory controller.
package dmem_ctrl_pkg;
    localparam int NUM_PORTS = 2;
    typedef enum logic [2:0] {F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101} funct3_e;
    typedef enum logic {IDLE, RMW_WR} state_e;
    function automatic logic access_err(logic [2:0] f3, logic we, logic [1:0] off);
        return (f3[1:0] == 2'b11) || (f3[2] && f3[1]) || (we && f3[2])
            || (f3[1:0] == 2'b01 && off[0]) || (f3 == F3_W && off != 2'b00);
    endfunction
    function automatic logic [31:0] lane_extract(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        return f3[1] ? w : f3[0] ? {{16{s[15] & ~f3[2]}}, s[15:0]} : {{24{s[7] & ~f3[2]}}, s[7:0]};
    endfunction
    function automatic logic [31:0] lane_merge(logic [31:0] w, logic [1:0] off, logic [2:0] f3, logic [31:0] d);
        logic [31:0] m;
        m = (f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {off, 3'b000};
        return (w & ~m) | ((d << {off, 3'b000}) & m);
    endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: requester-side bus of the data-memory controller, both ports packed per signal.
interface dmem_ctrl_if #(parameter int AW = 10, parameter int DW = 32);
    logic [dmem_ctrl_pkg::NUM_PORTS-1:0] req_i, we_i, gnt_o, rvalid_o, err_o;
    logic [dmem_ctrl_pkg::NUM_PORTS-1:0][2:0] funct3_i;
    logic [dmem_ctrl_pkg::NUM_PORTS-1:0][AW-1:0] addr_i;
    logic [dmem_ctrl_pkg::NUM_PORTS-1:0][DW-1:0] wdata_i, rdata_o;
    modport master (output req_i, we_i, funct3_i, addr_i, wdata_i, input gnt_o, rvalid_o, rdata_o, err_o);
    modport slave (input req_i, we_i, funct3_i, addr_i, wdata_i, output gnt_o, rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/dmem_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the port that did not win last time wins.
module rr_arbiter2
    import dmem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);
    logic rr_last;
    always_comb gnt = (!arst_n || !en) ? 2'b00 : (&req) ? (rr_last ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) rr_last <= 1'b1;
        else if (|gnt) rr_last <= gnt[1];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: shares a word-wide memory between two requesters, adding sub-word loads and RMW stores.
// Optional DMEM_CTRL_PERF_EN adds per-port saturating stall counters.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int DMEM_SZ_IN_KB = 1,
    localparam int ADDR_WIDTH    = $clog2(DMEM_SZ_IN_KB * 1024)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    dmem_ctrl_if.slave            bus,
    output logic                  mem_write_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DMEM_CTRL_PERF_EN
    ,
    output logic [NUM_PORTS-1:0][31:0] stall_cnt_o
`endif
);
    state_e state, state_n;
    logic [NUM_PORTS-1:0] gnt, rvalid, err;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;
    logic sel, any, bad, we, is_w, sub_st, hold_port;
    logic [2:0] f3, hold_f3;
    logic [ADDR_WIDTH-1:0] a, hold_addr;
    logic [DATA_WIDTH-1:0] wd, hold_wd, rmw_q;
    rr_arbiter2 u_arb (.clk(clk), .arst_n(arst_n), .en(state == IDLE), .req(bus.req_i), .gnt(gnt));
    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid;
    assign bus.err_o    = err;
    assign bus.rdata_o  = rdata;
    always_comb begin
        sel = gnt[1];
        any = |gnt;
        f3 = bus.funct3_i[sel];
        a = bus.addr_i[sel];
        wd = bus.wdata_i[sel];
        we = bus.we_i[sel];
        bad = access_err(f3, we, a[1:0]);
        is_w = f3 == F3_W;
        sub_st = any && !bad && we && !is_w;
        state_n = (state == IDLE && sub_st) ? RMW_WR : IDLE;
        mem_addr_o = state == RMW_WR ? hold_addr : any ? a : '0;
        mem_wdata_o = state == RMW_WR ? lane_merge(rmw_q, hold_addr[1:0], hold_f3, hold_wd) : wd;
        mem_write_en_o = arst_n && (state == RMW_WR || (any && !bad && we && is_w));
    end
    // Sub-word stores park their payload here so the write cycle ignores the bus.
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            state <= IDLE;
            rvalid <= '0;
            err <= '0;
            rdata <= '0;
            hold_port <= 1'b0;
            hold_f3 <= '0;
            hold_addr <= '0;
            hold_wd <= '0;
            rmw_q <= '0;
        end else begin
            state <= state_n;
            rvalid <= '0;
            err <= '0;
            if (state == RMW_WR) begin
                rvalid[hold_port] <= 1'b1;
                rdata[hold_port] <= '0;
            end else if (any && !sub_st) begin
                rvalid[sel] <= 1'b1;
                err[sel] <= bad;
                rdata[sel] <= (bad || we) ? '0 : lane_extract(mem_rdata_i, a[1:0], f3);
            end
            if (sub_st) begin
                hold_port <= sel;
                hold_f3 <= f3;
                hold_addr <= a;
                hold_wd <= wd;
                rmw_q <= mem_rdata_i;
            end
        end
`ifdef DMEM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) stall_cnt_o <= '0;
        else
            for (int i = 0; i < NUM_PORTS; i++)
                if (bus.req_i[i] && !gnt[i] && stall_cnt_o[i] != '1) stall_cnt_o[i] <= stall_cnt_o[i] + 32'd1;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl with a behavioural word memory.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic mem_we;
    logic [9:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [256];
    int tests = 0;
    int fails = 0;
    dmem_ctrl_if #(.AW(10), .DW(32)) bus ();
`ifdef DMEM_CTRL_PERF_EN
    logic [1:0][31:0] stall_cnt;
`endif
    dmem_ctrl dut (
        .clk(clk), .arst_n(arst_n), .bus(bus),
        .mem_write_en_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef DMEM_CTRL_PERF_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );
    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic we, input logic [2:0] f3, input logic [9:0] ad, input logic [31:0] wd);
        bus.req_i[p] = 1'b1;
        bus.we_i[p] = we;
        bus.funct3_i[p] = f3;
        bus.addr_i[p] = ad;
        bus.wdata_i[p] = wd;
    endtask

    task automatic access(input string tag, input int p, input logic we, input logic [2:0] f3, input logic [9:0] ad,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        logic rmw;
        rmw = we && !exp_err && f3 != 3'b010;
        drive(p, we, f3, ad, wd);
        #1;
        chk({tag, " gnt"}, 32'(bus.gnt_o), 32'(1 << p));
        chk({tag, " mem_we"}, 32'(mem_we), 32'(we && !exp_err && !rmw));
        if (!exp_err) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(ad));
        @(posedge clk);
        #1;
        if (rmw) begin
            chk({tag, " rmw gnt"}, 32'(bus.gnt_o), 32'd0);
            chk({tag, " rmw mem_we"}, 32'(mem_we), 32'd1);
            chk({tag, " rmw rvalid"}, 32'(bus.rvalid_o), 32'd0);
            bus.req_i = '0;
            @(posedge clk);
            #1;
        end
        bus.req_i = '0;
        chk({tag, " rvalid"}, 32'(bus.rvalid_o), 32'(1 << p));
        chk({tag, " err"}, 32'(bus.err_o[p]), 32'(exp_err));
        chk({tag, " rdata"}, bus.rdata_o[p], exp_rd);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.req_i = '0;
        bus.we_i = '0;
        bus.funct3_i = '0;
        bus.addr_i = '0;
        bus.wdata_i = '0;
        drive(0, 1'b1, 3'b010, 10'h10, 32'h1111_1111);
        #1;
        chk("rst gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("rst err", 32'(bus.err_o), 32'd0);
        chk("rst rdata0", bus.rdata_o[0], 32'd0);
        chk("rst rdata1", bus.rdata_o[1], 32'd0);
        bus.req_i = '0;
        #11 arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle mem_addr", 32'(mem_addr), 32'd0);

        access("sw 10", 0, 1'b1, 3'b010, 10'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access("lw 10", 0, 1'b0, 3'b010, 10'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access("sb 11", 0, 1'b1, 3'b000, 10'h11, 32'h0000_00A5, 32'h0, 1'b0);
        access("lw 10 b", 0, 1'b0, 3'b010, 10'h10, 32'h0, 32'hDEAD_A5EF, 1'b0);
        access("lb 11", 0, 1'b0, 3'b000, 10'h11, 32'h0, 32'hFFFF_FFA5, 1'b0);
        access("lbu 11", 0, 1'b0, 3'b100, 10'h11, 32'h0, 32'h0000_00A5, 1'b0);
        access("sw 20", 0, 1'b1, 3'b010, 10'h20, 32'h8001_1234, 32'h0, 1'b0);
        access("lh 22", 0, 1'b0, 3'b001, 10'h22, 32'h0, 32'hFFFF_8001, 1'b0);
        access("lhu 22 p1", 1, 1'b0, 3'b101, 10'h22, 32'h0, 32'h0000_8001, 1'b0);

        drive(0, 1'b0, 3'b010, 10'h10, 32'h0);
        drive(1, 1'b0, 3'b010, 10'h20, 32'h0);
        #1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("arb gnt %0d", k), 32'(bus.gnt_o), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
            chk($sformatf("arb rvalid %0d", k), 32'(bus.rvalid_o), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("arb rdata %0d", k), bus.rdata_o[k % 2], (k % 2 == 0) ? 32'hDEAD_A5EF : 32'h8001_1234);
        end
        bus.req_i = '0;

        access("lw 02 misal", 0, 1'b0, 3'b010, 10'h02, 32'h0, 32'h0, 1'b1);
        access("sh 13 misal", 0, 1'b1, 3'b001, 10'h13, 32'h0000_FFFF, 32'h0, 1'b1);
        access("sbu illegal", 0, 1'b1, 3'b100, 10'h10, 32'h0000_0077, 32'h0, 1'b1);
        access("f3 011 illegal", 0, 1'b0, 3'b011, 10'h10, 32'h0, 32'h0, 1'b1);
        access("lw 10 after err", 0, 1'b0, 3'b010, 10'h10, 32'h0, 32'hDEAD_A5EF, 1'b0);

        drive(0, 1'b1, 3'b000, 10'h10, 32'h0000_005A);
        #1;
        chk("sb rst gnt", 32'(bus.gnt_o), 32'd1);
        @(posedge clk);
        #1;
        chk("sb rst in rmw", 32'(mem_we), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("mid rst mem_we", 32'(mem_we), 32'd0);
        chk("mid rst gnt", 32'(bus.gnt_o), 32'd0);
        chk("mid rst rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("mid rst err", 32'(bus.err_o), 32'd0);
        chk("mid rst rdata0", bus.rdata_o[0], 32'd0);
        chk("mid rst rdata1", bus.rdata_o[1], 32'd0);
        bus.req_i = '0;
        @(posedge clk);
        #3 arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst rvalid", 32'(bus.rvalid_o), 32'd0);
        drive(0, 1'b0, 3'b010, 10'h10, 32'h0);
        drive(1, 1'b0, 3'b010, 10'h20, 32'h0);
        #1;
        chk("post rst tie gnt", 32'(bus.gnt_o), 32'd1);
        @(posedge clk);
        #1;
        bus.req_i = '0;
        chk("post rst tie rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("mem 10 untouched", bus.rdata_o[0], 32'hDEAD_A5EF);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
